// File: rtl/button_pkg.sv
// Shared types and width helpers for the button conditioner.
// Phase encoding for the per-channel hold/repeat tracker.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        DONE
    } phase_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int db_w(input int db_cycles);
        return $clog2(db_cycles);
    endfunction

    function automatic int hold_w(input int hold_cycles, input int rep_cycles);
        return $clog2(max2(hold_cycles, rep_cycles));
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One channel: synchroniser, debounce window, hold/repeat tracker.
// All outputs are registered and cleared by synchronous reset.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DB_CYCLES     = 4194304,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_state,
    output logic btn_press,
    output logic btn_release,
    output logic long_press,
    output logic btn_repeat
);

    localparam int DW = db_w(DB_CYCLES);
    localparam int HW = hold_w(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic INV = (ACTIVE_LOW != 0);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    logic          s1, s2;
    logic [DW-1:0] db_cnt;
    logic          flip;
    logic          state_d;
    phase_t        phase, phase_d;
    logic [HW-1:0] hold_cnt, hold_cnt_d;
    logic          long_d, rep_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw ^ INV;
            s2 <= s1;
        end
    end

    assign flip    = (s2 != btn_state) && (db_cnt == DB_LAST);
    assign state_d = btn_state ^ flip;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt      <= '0;
            btn_state   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_state   <= state_d;
            btn_press   <= flip & ~btn_state;
            btn_release <= flip & btn_state;
            if ((s2 == btn_state) || flip)
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + 1'b1;
        end
    end

    // Decisions use the next debounced level so a release wins over a terminal count.
    always_comb begin
        phase_d    = phase;
        hold_cnt_d = hold_cnt;
        long_d     = 1'b0;
        rep_d      = 1'b0;
        if (!state_d) begin
            phase_d    = IDLE;
            hold_cnt_d = '0;
        end else begin
            unique case (phase)
                IDLE: begin
                    phase_d    = HOLD;
                    hold_cnt_d = '0;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        long_d     = 1'b1;
                        hold_cnt_d = '0;
                        phase_d    = (REPEAT_EN != 0) ? REPEAT : DONE;
                    end else begin
                        hold_cnt_d = hold_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (hold_cnt == REP_LAST) begin
                        rep_d      = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt + 1'b1;
                    end
                end
                DONE: begin
                    hold_cnt_d = hold_cnt;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= IDLE;
            hold_cnt   <= '0;
            long_press <= 1'b0;
            btn_repeat <= 1'b0;
        end else begin
            phase      <= phase_d;
            hold_cnt   <= hold_cnt_d;
            long_press <= long_d;
            btn_repeat <= rep_d;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button debouncer with press/release, long-press and repeat pulses.
// Each channel is an independent debounce_channel instance.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DB_CYCLES     = 4194304,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] btn_repeat
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raw[i]),
            .btn_state  (btn_state[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .long_press (long_press[i]),
            .btn_repeat (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: reference model queues expected outputs, monitor compares.
// Two DUTs (active-high and active-low) share one reference stream.
module tb_button_conditioner;

    localparam int N    = 2;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lp;
        logic [1:0] rp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_raw = 2'b11;
    logic [1:0] raw_n;
    logic [1:0] a_st, a_pr, a_rl, a_lp, a_rp;
    logic [1:0] b_st, b_pr, b_rl, b_lp, b_rp;

    assign raw_n = ~btn_raw;

    button_conditioner #(
        .N_CH(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
        .REPEAT_EN(1), .REPEAT_CYCLES(REP), .ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_state(a_st), .btn_press(a_pr), .btn_release(a_rl),
        .long_press(a_lp), .btn_repeat(a_rp)
    );

    button_conditioner #(
        .N_CH(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
        .REPEAT_EN(1), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_raw(raw_n),
        .btn_state(b_st), .btn_press(b_pr), .btn_release(b_rl),
        .long_press(b_lp), .btn_repeat(b_rp)
    );

    always #5 clk = ~clk;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_lp = 0, exp_rp = 0, exp_pr = 0;
    int   dut_lp = 0, dut_rp = 0, dut_pr = 0;

    // Reference model state: sampled-input history, mismatch run length,
    // and edges elapsed since the debounced press.
    bit   m_h1[2], m_h2[2], m_st[2];
    int   m_run[2], m_k[2];

    task automatic note_fail(input string name, input logic [31:0] got,
                             input logic [31:0] need);
        fails++;
        if (fails <= 20)
            $display("FAIL %s got=%h need=%h t=%0t", name, got, need, $time);
    endtask

    task automatic model_step(input bit r, input logic [1:0] raw, output exp_t e);
        bit s, prev;
        e = '0;
        for (int c = 0; c < N; c++) begin
            if (r) begin
                m_h1[c] = 0; m_h2[c] = 0; m_st[c] = 0;
                m_run[c] = 0; m_k[c] = 0;
            end else begin
                s = m_h2[c];
                m_h2[c] = m_h1[c];
                m_h1[c] = raw[c];
                prev = m_st[c];
                if (s == m_st[c]) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_st[c] = !m_st[c];
                        m_run[c] = 0;
                    end
                end
                e.st[c] = m_st[c];
                e.pr[c] = m_st[c] && !prev;
                e.rl[c] = !m_st[c] && prev;
                if (m_st[c]) begin
                    m_k[c] = prev ? m_k[c] + 1 : 0;
                    e.lp[c] = (m_k[c] == HOLD);
                    e.rp[c] = (m_k[c] > HOLD) && ((m_k[c] - HOLD) % REP == 0);
                end else begin
                    m_k[c] = 0;
                end
            end
        end
        exp_lp += int'(e.lp[0]) + int'(e.lp[1]);
        exp_rp += int'(e.rp[0]) + int'(e.rp[1]);
        exp_pr += int'(e.pr[0]) + int'(e.pr[1]);
    endtask

    task automatic cycle(input bit r, input logic [1:0] raw);
        exp_t e;
        rst = r;
        btn_raw = raw;
        @(posedge clk);
        model_step(r, raw, e);
        sb_a.push_back(e);
        sb_b.push_back(e);
        #1;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb_a.size() > 0) begin
            mon_e = sb_a.pop_front();
            tests++;
            if ({a_st, a_pr, a_rl, a_lp, a_rp} !== mon_e)
                note_fail("dut_a", 32'({a_st, a_pr, a_rl, a_lp, a_rp}), 32'(mon_e));
            dut_lp += int'(a_lp[0]) + int'(a_lp[1]);
            dut_rp += int'(a_rp[0]) + int'(a_rp[1]);
            dut_pr += int'(a_pr[0]) + int'(a_pr[1]);
        end
        if (sb_b.size() > 0) begin
            mon_e = sb_b.pop_front();
            tests++;
            if ({b_st, b_pr, b_rl, b_lp, b_rp} !== mon_e)
                note_fail("dut_b", 32'({b_st, b_pr, b_rl, b_lp, b_rp}), 32'(mon_e));
        end
    end

    int         lat;
    int         seg[2];
    logic [1:0] lvl;
    bit         r;

    initial begin
        // Reset with both buttons pressed, then measure rise latency.
        repeat (3) cycle(1'b1, 2'b11);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cycle(1'b0, 2'b11);
            if (a_st[0]) lat = i;
        end
        tests++;
        if (lat != DB + 2) note_fail("latency", 32'(lat), 32'(DB + 2));
        repeat (15) cycle(1'b0, 2'b00);

        // Bounce shorter than the window.
        repeat (3) cycle(1'b0, 2'b01);
        repeat (12) cycle(1'b0, 2'b00);

        // Press, then release so the debounced fall lands on the first repeat edge.
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 2'b01);
            if (m_st[0] && m_k[0] == HOLD + REP - DB - 2) break;
        end
        repeat (15) cycle(1'b0, 2'b00);

        // Long hold with several repeats.
        repeat (40) cycle(1'b0, 2'b01);
        repeat (15) cycle(1'b0, 2'b00);

        // Both channels on the same edge.
        repeat (30) cycle(1'b0, 2'b11);
        repeat (15) cycle(1'b0, 2'b00);

        // Reset mid-hold, then re-debounce and count from scratch.
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 2'b01);
            if (m_st[0] && m_k[0] == 8) break;
        end
        repeat (2) cycle(1'b1, 2'b01);
        repeat (30) cycle(1'b0, 2'b01);
        repeat (15) cycle(1'b0, 2'b00);

        // Randomised segments with short glitches and occasional reset.
        seg[0] = 0;
        seg[1] = 0;
        lvl = 2'b00;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (seg[c] == 0) begin
                    lvl[c] = 1'($urandom_range(0, 1));
                    seg[c] = ($urandom_range(0, 3) == 0) ?
                             int'($urandom_range(1, 4)) :
                             int'($urandom_range(5, 30));
                end
                seg[c]--;
            end
            r = ($urandom_range(0, 299) == 0);
            cycle(r, lvl);
        end
        repeat (3) cycle(1'b0, 2'b00);

        @(negedge clk);
        #1;
        tests++;
        if (sb_a.size() != 0 || sb_b.size() != 0)
            note_fail("drain", 32'(sb_a.size()), 32'd0);
        tests++;
        if (dut_lp != exp_lp) note_fail("long_cnt", 32'(dut_lp), 32'(exp_lp));
        tests++;
        if (dut_rp != exp_rp) note_fail("rep_cnt", 32'(dut_rp), 32'(exp_rp));
        tests++;
        if (dut_pr != exp_pr) note_fail("press_cnt", 32'(dut_pr), 32'(exp_pr));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
